// File: rtl/frame_column_loader_if.sv
// Configuration-word handshake and column-facing frame outputs of the loader.
interface frame_column_loader_if #(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20
);
  logic [FrameBitsPerRow-1:0] cfg_data;
  logic                       cfg_is_addr;
  logic                       cfg_valid;
  logic                       cfg_ready;
  logic                       clear_error;
  logic [FrameBitsPerRow-1:0] frame_data;
  logic [MaxFramesPerCol-1:0] frame_strobe;
  logic                       error;
  logic [7:0]                 frames_written;

  modport master (
    output cfg_data, cfg_is_addr, cfg_valid, clear_error,
    input  cfg_ready, frame_data, frame_strobe, error, frames_written
  );

  modport slave (
    input  cfg_data, cfg_is_addr, cfg_valid, clear_error,
    output cfg_ready, frame_data, frame_strobe, error, frames_written
  );
endinterface

// File: rtl/frame_column_loader.sv
// Loads configuration frames into a fabric column: address words select a frame,
// data words run a SETUP / STROBE / HOLD write sequence on the selected strobe line.
module frame_column_loader #(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int StrobeWidth     = 2
) (
  input  logic                  i_user_clk,
  input  logic                  i_reset,
  frame_column_loader_if.slave  io_cfg
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [5:0] FramesLimit   = 6'(MaxFramesPerCol);
  localparam logic [4:0] LastIdx       = 5'(MaxFramesPerCol - 1);
  localparam logic [3:0] LastStrobeCnt = 4'(StrobeWidth - 1);

  state_t                     r_state;
  logic [4:0]                 r_frame_idx;
  logic [3:0]                 r_strobe_cnt;
  logic [FrameBitsPerRow-1:0] r_frame_data;
  logic [MaxFramesPerCol-1:0] r_frame_strobe;
  logic                       r_error;
  logic [7:0]                 r_frames_written;

  logic                       w_accept;
  logic                       w_addr_legal;
  logic [MaxFramesPerCol-1:0] w_onehot;
  logic [4:0]                 w_next_idx;

  // Handshake qualification, address legality, strobe decode and wrapping increment.
  always_comb begin
    w_accept     = io_cfg.cfg_valid & (r_state == IDLE) & ~i_reset;
    w_addr_legal = ({1'b0, io_cfg.cfg_data[4:0]} < FramesLimit);
    w_onehot     = {{(MaxFramesPerCol-1){1'b0}}, 1'b1} << r_frame_idx;
    if (r_frame_idx == LastIdx) begin
      w_next_idx = 5'd0;
    end else begin
      w_next_idx = r_frame_idx + 5'd1;
    end
  end

  assign io_cfg.cfg_ready      = (r_state == IDLE) & ~i_reset;
  assign io_cfg.frame_data     = r_frame_data;
  assign io_cfg.frame_strobe   = r_frame_strobe;
  assign io_cfg.error          = r_error;
  assign io_cfg.frames_written = r_frames_written;

  // Write-sequence FSM with all column-facing outputs registered.
  always_ff @(posedge i_user_clk) begin
    if (i_reset) begin
      r_state          <= IDLE;
      r_frame_idx      <= 5'd0;
      r_strobe_cnt     <= 4'd0;
      r_frame_data     <= '0;
      r_frame_strobe   <= '0;
      r_error          <= 1'b0;
      r_frames_written <= 8'd0;
    end else begin
      // A rejected address in the same cycle as a clear keeps the flag set.
      if (w_accept && io_cfg.cfg_is_addr && !w_addr_legal) begin
        r_error <= 1'b1;
      end else if (io_cfg.clear_error) begin
        r_error <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (io_cfg.cfg_is_addr) begin
              if (w_addr_legal) begin
                r_frame_idx <= io_cfg.cfg_data[4:0];
              end
            end else begin
              r_frame_data <= io_cfg.cfg_data;
              r_state      <= SETUP;
            end
          end
        end
        SETUP: begin
          r_strobe_cnt   <= 4'd0;
          r_frame_strobe <= w_onehot;
          r_state        <= STROBE;
        end
        STROBE: begin
          if (r_strobe_cnt == LastStrobeCnt) begin
            r_frame_strobe <= '0;
            r_state        <= HOLD;
          end else begin
            r_strobe_cnt <= r_strobe_cnt + 4'd1;
          end
        end
        HOLD: begin
          if (r_frames_written != 8'hFF) begin
            r_frames_written <= r_frames_written + 8'd1;
          end
          r_frame_idx <= w_next_idx;
          r_state     <= IDLE;
        end
        default: begin
          r_frame_strobe <= '0;
          r_state        <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_frame_column_loader.sv
// Self-checking bench: directed vector table, directed multi-cycle sequences and
// randomized traffic compared against a cycle-timeline reference model.
module tb_frame_column_loader;
  localparam int MAX = 20;
  localparam int FB  = 32;
  localparam int SW  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  frame_column_loader_if #(.FrameBitsPerRow(FB), .MaxFramesPerCol(MAX)) cfg_if ();

  frame_column_loader #(
    .MaxFramesPerCol(MAX),
    .FrameBitsPerRow(FB),
    .StrobeWidth(SW)
  ) dut (
    .i_user_clk(clk),
    .i_reset(rst),
    .io_cfg(cfg_if)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          r, v, a, c;
    logic [31:0] d;
    bit          e_rdy;
    logic [19:0] e_stb;
    bit          e_err;
    logic [7:0]  e_fw;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, v, a, input logic [31:0] d, input bit c,
                     input bit er, input logic [19:0] es, input bit ee,
                     input logic [7:0] ef, input logic [31:0] ed);
    vec_t x;
    x.r = r; x.v = v; x.a = a; x.d = d; x.c = c;
    x.e_rdy = er; x.e_stb = es; x.e_err = ee; x.e_fw = ef; x.e_data = ed;
    tbl.push_back(x);
  endtask

  // Reference model: time since a data word was accepted decides every output.
  int          m_idx, m_fw, m_phase;
  bit          m_err;
  logic [31:0] m_data;

  task automatic model_edge(input bit r, v, a, input logic [31:0] d, input bit c, output bit acc);
    bit legal;
    acc = 1'b0;
    if (r) begin
      m_idx = 0; m_fw = 0; m_err = 1'b0; m_data = 32'd0; m_phase = -1;
    end else begin
      legal = (d[4:0] < MAX);
      if (m_phase < 0 && v && a && !legal) m_err = 1'b1;
      else if (c) m_err = 1'b0;
      if (m_phase >= 0) begin
        m_phase++;
        if (m_phase == SW + 3) begin
          m_phase = -1;
          if (m_fw < 255) m_fw++;
          m_idx = (m_idx + 1) % MAX;
        end
      end else if (v) begin
        acc = 1'b1;
        if (a) begin
          if (legal) m_idx = int'(d[4:0]);
        end else begin
          m_data  = d;
          m_phase = 1;
        end
      end
    end
  endtask

  task automatic drive(input bit r, v, a, input logic [31:0] d, input bit c);
    rst                = r;
    cfg_if.cfg_valid   = v;
    cfg_if.cfg_is_addr = a;
    cfg_if.cfg_data    = d;
    cfg_if.clear_error = c;
  endtask

  task automatic step(input bit r, v, a, input logic [31:0] d, input bit c, output bit acc);
    logic [63:0] exp_stb;
    drive(r, v, a, d, c);
    model_edge(r, v, a, d, c, acc);
    @(posedge clk);
    #1;
    exp_stb = (m_phase >= 2 && m_phase <= SW + 1) ? (64'd1 << m_idx) : 64'd0;
    check("ready", 64'(cfg_if.cfg_ready), 64'((m_phase < 0) && !r));
    check("strobe", 64'(cfg_if.frame_strobe), exp_stb);
    check("data", 64'(cfg_if.frame_data), 64'(m_data));
    check("error", 64'(cfg_if.error), 64'(m_err));
    check("frames_written", 64'(cfg_if.frames_written), 64'(m_fw));
  endtask

  bit          acc;
  logic [31:0] words[2];
  int          k, rises, rise_cyc[2], ready_low, n_data, n_stb, n_overlap;
  logic [19:0] rise_val[2], prev_stb;
  bit          hold, wa, wc;
  logic [31:0] wd;

  initial begin
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);

    // r v a data c | rdy strobe err fw data
    add(1, 0, 0, 32'h0000_0000, 0, 0, 20'h00000, 0, 8'd0, 32'h0000_0000);
    add(1, 0, 0, 32'h0000_0000, 0, 0, 20'h00000, 0, 8'd0, 32'h0000_0000);
    add(0, 0, 0, 32'h0000_0000, 0, 1, 20'h00000, 0, 8'd0, 32'h0000_0000);
    add(0, 1, 1, 32'h0000_0003, 0, 1, 20'h00000, 0, 8'd0, 32'h0000_0000);
    add(0, 1, 0, 32'hA5A5_0001, 0, 0, 20'h00000, 0, 8'd0, 32'hA5A5_0001);
    add(0, 0, 0, 32'h0000_0000, 0, 0, 20'h00008, 0, 8'd0, 32'hA5A5_0001);
    add(0, 0, 0, 32'h0000_0000, 0, 0, 20'h00008, 0, 8'd0, 32'hA5A5_0001);
    add(0, 0, 0, 32'h0000_0000, 0, 0, 20'h00000, 0, 8'd0, 32'hA5A5_0001);
    add(0, 0, 0, 32'h0000_0000, 0, 1, 20'h00000, 0, 8'd1, 32'hA5A5_0001);
    add(0, 1, 0, 32'h0000_1234, 0, 0, 20'h00000, 0, 8'd1, 32'h0000_1234);
    add(0, 0, 0, 32'h0000_0000, 0, 0, 20'h00010, 0, 8'd1, 32'h0000_1234);
    add(0, 0, 0, 32'h0000_0000, 0, 0, 20'h00010, 0, 8'd1, 32'h0000_1234);
    add(0, 0, 0, 32'h0000_0000, 0, 0, 20'h00000, 0, 8'd1, 32'h0000_1234);
    add(0, 0, 0, 32'h0000_0000, 0, 1, 20'h00000, 0, 8'd2, 32'h0000_1234);
    add(0, 1, 1, 32'h0000_0019, 0, 1, 20'h00000, 1, 8'd2, 32'h0000_1234);
    add(0, 1, 1, 32'h0000_001E, 1, 1, 20'h00000, 1, 8'd2, 32'h0000_1234);
    add(0, 0, 0, 32'h0000_0000, 1, 1, 20'h00000, 0, 8'd2, 32'h0000_1234);
    add(0, 1, 0, 32'hCAFE_0000, 0, 0, 20'h00000, 0, 8'd2, 32'hCAFE_0000);
    add(0, 1, 0, 32'hDEAD_0000, 0, 0, 20'h00020, 0, 8'd2, 32'hCAFE_0000);
    add(0, 1, 0, 32'hDEAD_0000, 0, 0, 20'h00020, 0, 8'd2, 32'hCAFE_0000);
    add(0, 1, 0, 32'hDEAD_0000, 0, 0, 20'h00000, 0, 8'd2, 32'hCAFE_0000);
    add(0, 1, 0, 32'hDEAD_0000, 0, 1, 20'h00000, 0, 8'd3, 32'hCAFE_0000);
    add(0, 0, 0, 32'h0000_0000, 0, 1, 20'h00000, 0, 8'd3, 32'hCAFE_0000);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].c);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_ready", i), 64'(cfg_if.cfg_ready), 64'(tbl[i].e_rdy));
      check($sformatf("vec%0d_strobe", i), 64'(cfg_if.frame_strobe), 64'(tbl[i].e_stb));
      check($sformatf("vec%0d_error", i), 64'(cfg_if.error), 64'(tbl[i].e_err));
      check($sformatf("vec%0d_fw", i), 64'(cfg_if.frames_written), 64'(tbl[i].e_fw));
      check($sformatf("vec%0d_data", i), 64'(cfg_if.frame_data), 64'(tbl[i].e_data));
    end

    // Reset landing in the second strobe cycle aborts the write.
    step(1, 0, 0, 32'd0, 0, acc);
    step(0, 0, 0, 32'd0, 0, acc);
    step(0, 1, 1, 32'd2, 0, acc);
    step(0, 1, 0, 32'hDEAD_BEEF, 0, acc);
    step(0, 0, 0, 32'd0, 0, acc);
    step(0, 0, 0, 32'd0, 0, acc);
    check("abort_in_strobe", 64'(cfg_if.frame_strobe), 64'h4);
    step(1, 0, 0, 32'd0, 0, acc);
    check("abort_strobe_dropped", 64'(cfg_if.frame_strobe), 64'h0);
    step(0, 0, 0, 32'd0, 0, acc);
    check("abort_ready_after", 64'(cfg_if.cfg_ready), 64'h1);
    check("abort_fw", 64'(cfg_if.frames_written), 64'h0);

    // Last frame then wrap to frame 0 with valid held high.
    step(0, 1, 1, 32'd19, 0, acc);
    words[0] = 32'h1111_0013;
    words[1] = 32'h2222_0000;
    k = 0; rises = 0; ready_low = 0; prev_stb = '0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      step(0, k < 2, 0, (k < 2) ? words[k] : 32'd0, 0, acc);
      if (acc) k++;
      if (!cfg_if.cfg_ready) ready_low++;
      if (prev_stb == '0 && cfg_if.frame_strobe != '0 && rises < 2) begin
        rise_cyc[rises] = cyc;
        rise_val[rises] = cfg_if.frame_strobe;
        rises++;
      end
      prev_stb = cfg_if.frame_strobe;
    end
    check("wrap_rises", 64'(rises), 64'd2);
    check("wrap_first_bit19", 64'(rise_val[0]), 64'h80000);
    check("wrap_second_bit0", 64'(rise_val[1]), 64'h1);
    check("wrap_spacing", 64'(rise_cyc[1] - rise_cyc[0]), 64'd5);
    check("wrap_ready_low", 64'(ready_low), 64'd8);

    // Frame counter saturation.
    step(1, 0, 0, 32'd0, 0, acc);
    k = 0;
    for (int cyc = 0; cyc < 256 * (SW + 3) + 20 && k < 256; cyc++) begin
      step(0, 1, 0, $urandom, 0, acc);
      if (acc) k++;
    end
    check("sat_accepted", 64'(k), 64'd256);
    for (int i = 0; i < SW + 3; i++) step(0, 0, 0, 32'd0, 0, acc);
    check("sat_fw_255", 64'(cfg_if.frames_written), 64'd255);

    // Randomized traffic with stalls; words are held until accepted.
    step(1, 0, 0, 32'd0, 0, acc);
    hold = 0; wa = 0; wd = 32'd0; n_data = 0; n_stb = 0; n_overlap = 0;
    for (int i = 0; i < 3000 + SW + 3; i++) begin
      if (i < 3000 && !hold && $urandom_range(0, 1) == 1) begin
        hold = 1'b1;
        wa   = ($urandom_range(0, 3) == 0);
        wd   = $urandom;
      end
      wc = ($urandom_range(0, 15) == 0);
      step(0, hold, wa, wd, wc, acc);
      if (acc) begin
        hold = 1'b0;
        if (!wa) n_data++;
      end
      if (cfg_if.frame_strobe != '0) n_stb++;
      if (cfg_if.frame_strobe != '0 && cfg_if.cfg_ready) n_overlap++;
    end
    check("rand_strobe_cycles", 64'(n_stb), 64'(n_data * SW));
    check("rand_strobe_while_ready", 64'(n_overlap), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/frame_column_loader.md
FRAME_COLUMN_LOADER -- requirements
Module: frame_column_loader

Interface
REQ-001 Parameter MaxFramesPerCol, default 20: number of frame strobes driven into the column.
REQ-002 Parameter FrameBitsPerRow, default 32: frame data word width.
REQ-003 Parameter StrobeWidth, default 2: cycles FrameStrobe stays high per frame write; legal range 1..15.
REQ-004 UserCLK  input  1: the single clock; all state changes on its rising edge.
REQ-005 Reset  input  1: synchronous, active-high reset, sampled on the UserCLK rising edge.
REQ-006 CfgData  input  FrameBitsPerRow: configuration word from the bitstream source.
REQ-007 CfgIsAddr  input  1: 1 means CfgData is a frame-address word; 0 means a frame-data word.
REQ-008 CfgValid  input  1: CfgData/CfgIsAddr valid this cycle.
REQ-009 CfgReady  output  1: loader can accept a word this cycle.
REQ-010 ClearError  input  1: clears the sticky error flag.
REQ-011 FrameData  output  FrameBitsPerRow: registered frame word into the column's terminal tile.
REQ-012 FrameStrobe  output  MaxFramesPerCol: registered one-hot/zero frame strobe into the column.
REQ-013 Error  output  1: sticky illegal-address flag.
REQ-014 FramesWritten  output  8: count of completed frame writes since reset, saturating at 255.

Function
REQ-015 A word transfers only on a cycle with CfgValid=1 and CfgReady=1; CfgReady is 1 only in state IDLE with Reset=0.
REQ-016 States: IDLE, SETUP, STROBE, HOLD; the FSM and all outputs are fully registered.
REQ-017 Accepted address word: if CfgData[4:0] < MaxFramesPerCol, FrameIdx <= CfgData[4:0]; otherwise FrameIdx unchanged and Error <= 1; FSM stays IDLE; no strobe.
REQ-018 Accepted data word: FrameData <= CfgData on the accepting edge; IDLE -> SETUP.
REQ-019 SETUP lasts exactly 1 cycle, FrameStrobe all zero; SETUP -> STROBE.
REQ-020 STROBE lasts exactly StrobeWidth cycles with FrameStrobe[FrameIdx]=1 and all other bits 0; STROBE -> HOLD.
REQ-021 HOLD lasts exactly 1 cycle, FrameStrobe all zero, FrameData unchanged; HOLD -> IDLE, FramesWritten increments (saturating), FrameIdx auto-increments.
REQ-022 Auto-increment wraps: FrameIdx = MaxFramesPerCol-1 -> 0.
REQ-023 FrameData is stable from SETUP through HOLD; it changes only on acceptance of a data word.
REQ-024 Data-word busy window is StrobeWidth+2 cycles; next acceptance is possible on the first IDLE cycle, giving back-to-back throughput of one frame per StrobeWidth+3 cycles.
REQ-025 Words presented while CfgReady=0 are not consumed; CfgData/CfgIsAddr/CfgValid must be held by the source.
REQ-026 Error does not block operation: data words after an illegal address write to the retained FrameIdx.
REQ-027 ClearError=1 clears Error next edge; if an illegal address is accepted in the same cycle, Error stays 1 (set wins).
REQ-028 Counter internal to STROBE is wide enough for StrobeWidth up to 15; no other arithmetic exceeds declared widths.

Reset
REQ-029 Reset=1 forces next edge: state IDLE, FrameIdx 0, FrameData 0, FrameStrobe 0, Error 0, FramesWritten 0, CfgReady 0 while Reset is high.
REQ-030 Reset asserted mid-write (any of SETUP/STROBE/HOLD) aborts the write: strobe drops at that edge, FramesWritten not incremented, no partial frame counted.
REQ-031 First cycle after Reset deasserts: CfgReady=1.

Verification
REQ-032 Reset, addr word 0x03, data word 0xA5A5_0001 -> SETUP 1 cycle, FrameStrobe=0x00008 for 2 cycles, HOLD, FrameData=0xA5A5_0001 throughout, FramesWritten=1, FrameIdx=4.
REQ-033 Addr 19, two data words CfgValid held high -> strobes on bit 19 then bit 0 (wrap), CfgReady low 4 cycles each, 5 cycles between strobe rising edges.
REQ-034 Addr 25 -> Error=1, FrameIdx unchanged; ClearError and addr 30 same cycle -> Error stays 1; ClearError alone -> Error=0 next cycle.
REQ-035 Reset pulsed during 2nd STROBE cycle -> FrameStrobe=0 and FrameData=0 next edge, FramesWritten unchanged, CfgReady=1 after release.
REQ-036 256 data writes -> FramesWritten saturates at 255; random CfgValid with stalls -> every accepted data word yields exactly one strobe of StrobeWidth cycles, none while CfgReady=1.
